// File: rtl/i2s_tx32.sv
// i2s_tx32: 32-bit stereo serial transmitter, 64 bit clocks per frame, MSB first.
// Left-justified framing by default; define I2S_TX_DELAY_EN for Philips I2S olrck timing.
module i2s_tx32 #(
   parameter int unsigned BCK_DIV = 8
) (
   input  logic        pclk,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [31:0] ldata,
   input  logic [31:0] rdata,
   output logic        in_ready,
   output logic        obick,
   output logic        olrck,
   output logic        osdata,
   output logic        underrun
);

   logic [7:0]  div_cnt_r;
   logic [5:0]  bit_cnt_r;
   logic [63:0] shift_r;
   logic [31:0] hold_l_r;
   logic [31:0] hold_r_r;
   logic        hold_full_r;

   logic        tick_s;
   logic        fall_evt_s;
   logic        frame_start_s;
   logic        accept_s;
   logic        hold_full_nxt_s;
   logic [5:0]  bit_cnt_nxt_s;
   logic [63:0] shift_nxt_s;
   logic        lrck_nxt_s;

   // Decode divider events and compute next framing/datapath values
   always_comb begin
      tick_s        = (div_cnt_r == 8'(BCK_DIV - 1));
      fall_evt_s    = tick_s & obick;
      bit_cnt_nxt_s = bit_cnt_r + 6'd1;
      frame_start_s = fall_evt_s & (bit_cnt_r == 6'd63);
      accept_s      = in_valid & in_ready;

      if (frame_start_s) begin
         if (hold_full_r) begin
            shift_nxt_s = {hold_l_r, hold_r_r};
         end else begin
            shift_nxt_s = 64'd0;
         end
      end else begin
         shift_nxt_s = {shift_r[62:0], 1'b0};
      end

      // Transfer needs a full holder while acceptance needs an empty one
      if (frame_start_s && hold_full_r) begin
         hold_full_nxt_s = 1'b0;
      end else if (accept_s) begin
         hold_full_nxt_s = 1'b1;
      end else begin
         hold_full_nxt_s = hold_full_r;
      end

`ifdef I2S_TX_DELAY_EN
      if (bit_cnt_nxt_s == 6'd63) begin
         lrck_nxt_s = 1'b0;
      end else if (bit_cnt_nxt_s == 6'd31) begin
         lrck_nxt_s = 1'b1;
      end else begin
         lrck_nxt_s = olrck;
      end
`else
      if (bit_cnt_nxt_s == 6'd0) begin
         lrck_nxt_s = 1'b0;
      end else if (bit_cnt_nxt_s == 6'd32) begin
         lrck_nxt_s = 1'b1;
      end else begin
         lrck_nxt_s = olrck;
      end
`endif
   end

   // Divider, bit counter, shift/hold registers and all registered outputs
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt_r   <= 8'd0;
         bit_cnt_r   <= 6'd63;
         shift_r     <= 64'd0;
         hold_l_r    <= 32'd0;
         hold_r_r    <= 32'd0;
         hold_full_r <= 1'b0;
         obick       <= 1'b0;
         olrck       <= 1'b0;
         osdata      <= 1'b0;
         underrun    <= 1'b0;
         in_ready    <= 1'b1;
      end else begin
         underrun <= 1'b0;
         if (tick_s) begin
            div_cnt_r <= 8'd0;
            obick     <= ~obick;
         end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
         end
         if (fall_evt_s) begin
            bit_cnt_r <= bit_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            osdata    <= shift_nxt_s[63];
            olrck     <= lrck_nxt_s;
            underrun  <= frame_start_s & ~hold_full_r;
         end
         if (accept_s) begin
            hold_l_r <= ldata;
            hold_r_r <= rdata;
         end
         hold_full_r <= hold_full_nxt_s;
         in_ready    <= ~hold_full_nxt_s;
      end
   end

endmodule

// File: tb/tb_i2s_tx32.sv
// Scoreboard bench for i2s_tx32: a frame-level reference model predicts frame contents,
// underrun pulses, bit-clock phase and in_ready from pclk counts since reset release.
module tb_i2s_tx32;

   localparam int BCK_DIV = 8;
   localparam int FIRST   = 2 * BCK_DIV;
   localparam int FRAME   = 128 * BCK_DIV;
`ifdef I2S_TX_DELAY_EN
   localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;
`else
   localparam logic [63:0] LR_EXP = 64'h0000_0000_FFFF_FFFF;
`endif

   logic        pclk = 1'b0;
   logic        reset_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] ldata = 32'd0;
   logic [31:0] rdata = 32'd0;
   logic        in_ready;
   logic        obick;
   logic        olrck;
   logic        osdata;
   logic        underrun;

   int errors = 0;
   int checks = 0;
   int frames = 0;

   // reference model state
   int          n = 0;
   logic        m_full = 1'b0;
   logic [31:0] m_l = 32'd0;
   logic [31:0] m_r = 32'd0;
   logic        exp_ur = 1'b0;
   logic [63:0] exp_q[$];

   // monitor state
   logic        prev_bck = 1'b0;
   int          rises = 0;
   logic [63:0] cap_w = 64'd0;
   logic [63:0] cap_lr = 64'd0;
   logic [63:0] exp_w;

   i2s_tx32 #(.BCK_DIV(BCK_DIV)) dut (
      .pclk(pclk), .reset_n(reset_n), .in_valid(in_valid), .ldata(ldata), .rdata(rdata),
      .in_ready(in_ready), .obick(obick), .olrck(olrck), .osdata(osdata), .underrun(underrun)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: frames begin every FRAME pclk, first at FIRST; a frame takes the held pair or is zero
   initial forever begin
      logic start;
      logic acc;
      @(posedge pclk or negedge reset_n);
      if (!reset_n) begin
         n = 0; m_full = 1'b0; exp_ur = 1'b0; exp_q.delete();
      end else begin
         n++;
         start  = (n >= FIRST) && (((n - FIRST) % FRAME) == 0);
         acc    = in_valid && !m_full;
         exp_ur = start && !m_full;
         if (start) begin
            if (m_full) begin
               exp_q.push_back({m_l, m_r});
               m_full = 1'b0;
            end else begin
               exp_q.push_back(64'd0);
            end
         end
         if (acc) begin
            m_l = ldata; m_r = rdata; m_full = 1'b1;
         end
      end
   end

   // Monitor: per-cycle outputs, then assemble 64 bits sampled on obick rises into frames
   initial forever begin
      @(negedge pclk);
      chk("obick", obick, ((n / BCK_DIV) % 2) != 0);
      chk("in_ready", in_ready, !m_full);
      chk("underrun", underrun, exp_ur);
      if (!reset_n) begin
         rises = 0;
      end else if (obick && !prev_bck) begin
         rises++;
         if (rises >= 2) begin
            cap_w  = {cap_w[62:0], osdata};
            cap_lr = {cap_lr[62:0], olrck};
            if (((rises - 2) % 64) == 63) begin
               frames++;
               chk("frame_queue_nonempty", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  exp_w = exp_q.pop_front();
                  chk("frame_data", cap_w, exp_w);
                  chk("frame_olrck", cap_lr, LR_EXP);
               end
            end
         end
      end
      prev_bck = obick;
   end

   task automatic wait_phase(input int ph);
      bit hit = 1'b0;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge pclk);
         if (n >= FIRST && ((n - FIRST) % FRAME) == ph) begin
            hit = 1'b1;
            break;
         end
      end
      chk("wait_phase_timeout", hit, 1'b1);
   endtask

   task automatic send(input logic [31:0] l, input logic [31:0] r);
      bit ok = 1'b0;
      ldata = l; rdata = r; in_valid = 1'b1;
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge pclk);
         if (in_ready) begin
            @(posedge pclk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      chk("send_timeout", ok, 1'b1);
   endtask

   initial begin
      logic [31:0] base;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge pclk);
      reset_n = 1'b1;

      // single pair before the first frame, then idle underrun frames
      send(32'h8000_0001, 32'h7FFF_FFFE);
      in_valid = 1'b0;
      repeat (3) wait_phase(FRAME - 1);

      // continuous back-pressure with incrementing words
      base = $urandom;
      for (int i = 0; i < 5; i++) send(base + 32'(2 * i), base + 32'(2 * i + 1));
      in_valid = 1'b0;
      repeat (2) wait_phase(FRAME - 1);

      // offer only in the frame-start cycle with the holder empty
      ldata = $urandom; rdata = $urandom; in_valid = 1'b1;
      @(posedge pclk);
      #1 in_valid = 1'b0;
      wait_phase(FRAME - 1);
      send($urandom, $urandom);
      in_valid = 1'b0;
      wait_phase(FRAME - 1);

      // asynchronous reset at bit 20 of the left word
      wait_phase(20 * 2 * BCK_DIV + BCK_DIV);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_obick", obick, 1'b0);
      chk("rst_olrck", olrck, 1'b0);
      chk("rst_osdata", osdata, 1'b0);
      chk("rst_underrun", underrun, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      repeat (4) @(negedge pclk);
      reset_n = 1'b1;

      // first frame after release is an underrun frame, then a patterned pair
      wait_phase(4);
      send(32'hA5A5_A5A5, $urandom);
      in_valid = 1'b0;
      repeat (2) wait_phase(FRAME - 1);

      chk("frames_seen", frames >= 12, 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
